// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-and-add unsigned multiplier.
//
// Purpose: replaces the single-cycle array multiplier on the ALU MUL path.
// The control unit pulses START, stalls while BUSY is high, and writes
// RESULT back on the one-cycle DONE pulse. RESULT carries the low product
// half; RESULT_HI carries the upper half.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-low reset
//   START      in   request, sampled on the rising edge
//   OPERAND1   in   [WIDTH]  multiplicand, latched on acceptance
//   OPERAND2   in   [WIDTH]  multiplier, latched on acceptance
//   RESULT     out  [WIDTH]  product bits [WIDTH-1:0]
//   RESULT_HI  out  [WIDTH]  product bits [2*WIDTH-1:WIDTH]
//   BUSY       out  high while a computation is in progress
//   DONE       out  one-cycle completion pulse
//
// Build option: define MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero (latency = index of top set bit of OPERAND2
// plus one, minimum one cycle). Without it the latency is fixed at WIDTH.

module mul_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc, mcand, res;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] acc_nxt;
  logic               accept;
  logic               last_step;

  // A request is taken in IDLE and also in the DONE cycle (back-to-back).
  assign accept  = START && (state == S_IDLE || state == S_DONE);

  // Full 2*WIDTH add: the product of two WIDTH-bit values always fits.
  assign acc_nxt = mplr[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no multiplier bits remain after this step's shift.
  assign last_step = (cnt == CW'(WIDTH - 1)) || ((mplr >> 1) == '0);
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_CALC;
      S_CALC:  if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = START ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      S_CALC:  BUSY = 1'b1;
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, one shift-add step per CALC cycle, and the
  // result register, which holds until the next completed operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      res   <= '0;
    end else if (accept) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, OPERAND1};
      mplr  <= OPERAND2;
      cnt   <= '0;
    end else if (state == S_CALC) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (last_step) res <= acc_nxt;
    end
  end

  assign RESULT    = res[WIDTH-1:0];
  assign RESULT_HI = res[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: directed vectors, scoreboard queue filled at
// issue time, separate monitor compares on every DONE pulse.
module tb_mul_sequencer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] OPERAND1 = '0;
  logic [W-1:0] OPERAND2 = '0;
  logic [W-1:0] RESULT, RESULT_HI;
  logic         BUSY, DONE;

  mul_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2),
    .RESULT(RESULT), .RESULT_HI(RESULT_HI),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse pops one expectation.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET && DONE) begin
        chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
        chk("busy_in_done", {31'b0, BUSY}, 32'd0);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got DONE with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_lo"}, {24'b0, RESULT}, {24'b0, e.lo});
          chk({e.name, "_hi"}, {24'b0, RESULT_HI}, {24'b0, e.hi});
          chk({e.name, "_lat"}, cyc - e.cyc, e.lat);
        end
        done_cnt++;
      end
      prev_done = RESET && DONE;
    end
  end

`ifdef MUL_EARLY_TERM_EN
  localparam int LAT_200x3 = 2;
  localparam int LAT_50x0  = 1;
`else
  localparam int LAT_200x3 = 8;
  localparam int LAT_50x0  = 8;
`endif

  // Drive a request from a negedge; it is accepted at the next posedge.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi, input int lat);
    exp_t e;
    START = 1'b1; OPERAND1 = a; OPERAND2 = b;
    @(posedge CLK); #1;
    e.lo = lo; e.hi = hi; e.lat = lat; e.cyc = cyc; e.name = name;
    sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int start_cnt;
    bit ok;
    start_cnt = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK); #1;
      if (done_cnt != start_cnt) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got no DONE in %0d cycles, expected DONE", name, bound);
    end
  endtask

  initial begin
    int busy_hi;
    bit seen;
    exp_t dropped;

    // Reset state
    #1;
    chk("rst_result", {24'b0, RESULT}, 32'd0);
    chk("rst_result_hi", {24'b0, RESULT_HI}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Basic product with BUSY window
    issue("basic_7x6", 8'd7, 8'd6, 8'h2A, 8'h00, 8);
    busy_hi = 1; // BUSY was high since the accepting edge
    for (int i = 0; i < 7; i++) begin
      if (BUSY) busy_hi++;
      @(negedge CLK);
    end
    chk("basic_busy_cycles", busy_hi, 32'd8);
    wait_done("basic_7x6", 20);
    @(negedge CLK);

    // Full scale
    issue("full_ffxff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 8);
    wait_done("full_ffxff", 20);
    @(negedge CLK);

    // START held during CALC is ignored; re-asserted in the DONE cycle is accepted
    issue("calc_3x5", 8'd3, 8'd5, 8'h0F, 8'h00, 8);
    START = 1'b1; OPERAND1 = 8'd9; OPERAND2 = 8'd9;
    repeat (3) @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 20 && !DONE; i++) @(negedge CLK);
    chk("calc_done_seen", {31'b0, DONE}, 32'd1);
    issue("b2b_9x9", 8'd9, 8'd9, 8'h51, 8'h00, 8);
    wait_done("b2b_9x9", 20);
    @(negedge CLK);

    // Reset mid-operation
    issue("abort_100x2", 8'd100, 8'd2, 8'hC8, 8'h00, 8);
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("abort_result", {24'b0, RESULT}, 32'd0);
    chk("abort_busy", {31'b0, BUSY}, 32'd0);
    chk("abort_done", {31'b0, DONE}, 32'd0);
    dropped = sb.pop_back();
    @(negedge CLK);
    RESET = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    chk("abort_no_done", {31'b0, seen}, 32'd0);
    issue("after_abort_20x3", 8'd20, 8'd3, 8'h3C, 8'h00, 8);
    wait_done("after_abort_20x3", 20);
    @(negedge CLK);

    // Operand changes during CALC have no effect
    issue("opchg_12x10", 8'd12, 8'd10, 8'h78, 8'h00, 8);
    for (int i = 0; i < 6; i++) begin
      OPERAND1 = 8'($urandom); OPERAND2 = 8'($urandom);
      @(negedge CLK);
    end
    wait_done("opchg_12x10", 20);
    @(negedge CLK);

    // Early termination cases (fixed latency without the option)
    issue("et_200x3", 8'd200, 8'd3, 8'h58, 8'h02, LAT_200x3);
    wait_done("et_200x3", 20);
    @(negedge CLK);
    issue("et_50x0", 8'd50, 8'd0, 8'h00, 8'h00, LAT_50x0);
    wait_done("et_50x0", 20);
    @(negedge CLK);

    // Result holds after completion and is not cleared by a new START
    repeat (2) @(negedge CLK);
    chk("hold_result", {24'b0, RESULT}, 32'd0);
    issue("hold_13x11", 8'd13, 8'd11, 8'h8F, 8'h00, 8);
    chk("hold_on_start", {24'b0, RESULT}, 32'd0);
    wait_done("hold_13x11", 20);
    repeat (3) @(negedge CLK);
    chk("hold_after_done", {24'b0, RESULT}, 32'h8F);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle shift-and-add 8x8 multiplier unit with start/busy/done handshake.
- Replaces the single-cycle ripple array multiplier on the ALU MUL path where array depth breaks the cycle budget.
- The CPU control unit pulses START, stalls the PC while BUSY is high, and writes RESULT to the register file on DONE.
- RESULT carries the low product byte, matching the ALU MUL semantics. RESULT_HI exposes the upper byte for future MULH use.

Parameters:
WIDTH, 8, operand width and width of each result half.

Ports:
CLK  input  1  rising-edge clock.
RESET  input  1  asynchronous, active-low reset.
START  input  1  request; sampled on the rising edge of CLK.
OPERAND1  input  WIDTH  multiplicand; latched when START is accepted.
OPERAND2  input  WIDTH  multiplier; latched when START is accepted.
RESULT  output  WIDTH  product bits [WIDTH-1:0].
RESULT_HI  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
BUSY  output  1  high while a computation is in progress.
DONE  output  1  one-cycle pulse; RESULT and RESULT_HI are valid from this cycle on.

Behaviour:
- Reset (RESET low, asynchronous):
  - State goes to IDLE.
  - RESULT=0, RESULT_HI=0, BUSY=0, DONE=0.
  - Internal accumulator, shifted multiplicand, multiplier and step counter all cleared.
  - A reset asserted mid-computation aborts it; no DONE is ever produced for the aborted operation.
- Internal registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits, zero-extended OPERAND1.
  - mplr: WIDTH bits.
  - cnt: clog2(WIDTH)+1 bits.
- States: IDLE, CALC, DONE.
- IDLE:
  - BUSY=0, DONE=0.
  - START=1 at an edge latches mcand={0,OPERAND1}, mplr=OPERAND2, acc=0, cnt=0, then moves to CALC.
- CALC (BUSY=1), one step per edge:
  - If mplr[0]=1, acc <= acc + mcand. Arithmetic is unsigned and 2*WIDTH wide; no carry-out is lost.
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt+1.
  - On the step where cnt==WIDTH-1: RESULT/RESULT_HI load the final acc value (including this step's add), then move to DONE.
- DONE:
  - DONE=1 and BUSY=0 for exactly one cycle.
  - START=1 in this cycle is accepted exactly as in IDLE (back-to-back issue, goes to CALC). Otherwise moves to IDLE.
- Latency: START accepted at edge N gives DONE high in the cycle after edge N+WIDTH, i.e. 8 CALC cycles for the default width.
- START while in CALC is ignored; it is neither queued nor does it disturb the in-flight operation.
- Operands are sampled only on acceptance. Changes to OPERAND1/OPERAND2 during CALC have no effect.
- RESULT/RESULT_HI hold their value until the next completed operation. They are not cleared on START.
- Zero operands are not special-cased; the full WIDTH steps run (see Optional Feature).

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, if the shifted multiplier value (mplr >> 1) is zero after the current step, the result loads and the state moves to DONE on that same edge, without waiting for cnt.
  - Latency is (index of highest set bit of OPERAND2)+1 cycles, with a minimum of 1 cycle when OPERAND2=0.
  - Products are identical to the undefined build.
- Undefined: fixed WIDTH-cycle latency; early-exit logic is absent from the netlist.

Test Plan:
- Basic product:
  - Reset, then START with OPERAND1=7, OPERAND2=6.
  - Required: RESULT=0x2A, RESULT_HI=0x00; DONE pulses exactly 8 cycles after the accepting edge; BUSY high for those 8 cycles.
- Full-scale product:
  - OPERAND1=0xFF, OPERAND2=0xFF.
  - Required: RESULT=0x01, RESULT_HI=0xFE; DONE is a single-cycle pulse.
- START during CALC:
  - START with 3*5, then hold START high with operands 9*9 for 3 cycles during CALC.
  - Required: first DONE gives RESULT=0x0F. The 9*9 request is accepted only if START is still high in the DONE cycle, giving a second DONE 8 cycles later with RESULT=0x51.
- Reset mid-operation:
  - Assert RESET low at CALC step 4 of 100*2.
  - Required: outputs go to 0 immediately without waiting for a clock edge; no DONE pulse; a new START 20*3 after release gives RESULT=0x3C.
- Operand change during CALC:
  - Change OPERAND1/OPERAND2 every cycle during a 12*10 operation.
  - Required: RESULT=0x78, RESULT_HI=0x00.
- Early termination:
  - With MUL_EARLY_TERM_EN defined: 200*3 gives DONE after 2 cycles, RESULT=0x58, RESULT_HI=0x02. 50*0 gives DONE after 1 cycle, RESULT=0.
  - Without the macro: both operations take 8 cycles and give the same values.
